axil_master_bridge: RTL

Upstream AXI4-Lite master that drives axi_lite_memory. It converts a simple valid/ready command interface (one read or write per command) into AXI4-Lite AW/W/B or AR/R transactions. It returns one response per command. One transaction is in flight at a time, so firmware-side or DMA-side logic can reach the memory without implementing AXI handshakes itself.

---
 rtl/axil_pkg.sv | 30 +++
 rtl/axil_master_bridge.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite command bridge: response codes, FSM
// state encoding and the latched command record.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // The command record is sized for the widest supported address; the bridge
    // zero-extends into it and truncates back out to its own ADDR_W.
    localparam int AXIL_ADDR_MAX = 64;

    typedef logic [2:0] axil_state_t;

    localparam axil_state_t ST_IDLE    = 3'd0;
    localparam axil_state_t ST_WR      = 3'd1;
    localparam axil_state_t ST_WR_RESP = 3'd2;
    localparam axil_state_t ST_RD_ADDR = 3'd3;
    localparam axil_state_t ST_RD_DATA = 3'd4;
    localparam axil_state_t ST_RSP     = 3'd5;

    typedef struct packed {
        logic                     write;
        logic [AXIL_ADDR_MAX-1:0] addr;
        logic [31:0]              wdata;
        logic [3:0]               wstrb;
    } axil_cmd_t;

endpackage

// File: rtl/axil_master_bridge.sv
// Single-outstanding AXI4-Lite master: turns one valid/ready command into one
// AW/W/B or AR/R transaction and hands back exactly one response per command.
module axil_master_bridge
    import axil_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int ERR_CNT_W = 16
) (
    input  logic                 ACLK,
    input  logic                 ARESETN,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [ADDR_W-1:0]    cmd_addr,
    input  logic [31:0]          cmd_wdata,
    input  logic [3:0]           cmd_wstrb,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_write,
    output logic [31:0]          rsp_rdata,
    output logic [1:0]           rsp_resp,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [ADDR_W-1:0]    M_AXIL_AWADDR,
    output logic                 M_AXIL_AWVALID,
    input  logic                 M_AXIL_AWREADY,
    output logic [31:0]          M_AXIL_WDATA,
    output logic [3:0]           M_AXIL_WSTRB,
    output logic                 M_AXIL_WVALID,
    input  logic                 M_AXIL_WREADY,
    input  logic [1:0]           M_AXIL_BRESP,
    input  logic                 M_AXIL_BVALID,
    output logic                 M_AXIL_BREADY,
    output logic [ADDR_W-1:0]    M_AXIL_ARADDR,
    output logic                 M_AXIL_ARVALID,
    input  logic                 M_AXIL_ARREADY,
    input  logic [31:0]          M_AXIL_RDATA,
    input  logic [1:0]           M_AXIL_RRESP,
    input  logic                 M_AXIL_RVALID,
    output logic                 M_AXIL_RREADY
);

    // Handshake rule on every channel: a transfer happens on a rising edge
    // where VALID and READY are both 1; VALID, once raised, stays up with a
    // stable payload until that edge and is never a function of READY.

    axil_state_t state;
    axil_cmd_t   cmd_q;
    logic        running;
    logic        aw_done;
    logic        w_done;

    logic        aw_hs;
    logic        w_hs;
    logic        b_hs;
    logic        r_hs;
    logic        aw_done_nx;
    logic        w_done_nx;
    logic [1:0]  cap_resp;
    logic        cap_err;

    // running holds cmd_ready low during reset and releases it on the first edge.
    assign cmd_ready      = running && (state == ST_IDLE);
    assign rsp_valid      = (state == ST_RSP);

    assign M_AXIL_AWVALID = (state == ST_WR) && !aw_done;
    assign M_AXIL_WVALID  = (state == ST_WR) && !w_done;
    assign M_AXIL_BREADY  = (state == ST_WR_RESP);
    assign M_AXIL_ARVALID = (state == ST_RD_ADDR);
    assign M_AXIL_RREADY  = (state == ST_RD_DATA);

    assign M_AXIL_AWADDR  = ADDR_W'(cmd_q.addr);
    assign M_AXIL_ARADDR  = ADDR_W'(cmd_q.addr);
    assign M_AXIL_WDATA   = cmd_q.wdata;
    assign M_AXIL_WSTRB   = cmd_q.wstrb;

    assign aw_hs      = M_AXIL_AWVALID && M_AXIL_AWREADY;
    assign w_hs       = M_AXIL_WVALID && M_AXIL_WREADY;
    assign b_hs       = M_AXIL_BVALID && M_AXIL_BREADY;
    assign r_hs       = M_AXIL_RVALID && M_AXIL_RREADY;
    assign aw_done_nx = aw_done || aw_hs;
    assign w_done_nx  = w_done || w_hs;
    assign cap_resp   = b_hs ? M_AXIL_BRESP : M_AXIL_RRESP;
    assign cap_err    = (b_hs || r_hs) && (cap_resp != RESP_OKAY);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state     <= ST_IDLE;
            cmd_q     <= '0;
            running   <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= RESP_OKAY;
            err_count <= '0;
        end else begin
            running <= 1'b1;

            if (cap_err && (err_count != '1)) begin
                err_count <= err_count + 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_q <= '{write: cmd_write,
                                   addr:  AXIL_ADDR_MAX'(cmd_addr),
                                   wdata: cmd_wdata,
                                   wstrb: cmd_wstrb};
                        state <= cmd_write ? ST_WR : ST_RD_ADDR;
                    end
                end
                ST_WR: begin
                    // AW and W complete independently; leave once both are in.
                    if (aw_done_nx && w_done_nx) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        state   <= ST_WR_RESP;
                    end else begin
                        aw_done <= aw_done_nx;
                        w_done  <= w_done_nx;
                    end
                end
                ST_WR_RESP: begin
                    if (b_hs) begin
                        rsp_write <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_resp  <= M_AXIL_BRESP;
                        state     <= ST_RSP;
                    end
                end
                ST_RD_ADDR: begin
                    if (M_AXIL_ARREADY) begin
                        state <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (r_hs) begin
                        rsp_write <= 1'b0;
                        rsp_rdata <= M_AXIL_RDATA;
                        rsp_resp  <= M_AXIL_RRESP;
                        state     <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
